// File: rtl/mdu.sv
// Iterative MIPS-style HI/LO multiply/divide unit: result 33 cycles after start, done pulses on the next cycle.
// No backpressure: start/mthi/mtlo are dropped while busy. Divider is built only with MDU_DIV_EN defined.
module mdu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_hi;
  logic [W-1:0]   acc_lo;
  logic [W-1:0]   opnd;
  logic           neg_q;
  logic           accept;
  logic           sgn;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     madd;
  logic [W-1:0]   it_hi;
  logic [W-1:0]   it_lo;
  logic [2*W-1:0] prod;
  logic [W-1:0]   fx_hi;
  logic [W-1:0]   fx_lo;

`ifdef MDU_DIV_EN
  logic           is_div;
  logic           neg_r;
  logic           div0;
  logic [W:0]     shifted;
  logic [W-1:0]   rem_sub;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
`endif

  assign busy  = (state != IDLE);
  assign sgn   = ~op[0];
  assign a_mag = (sgn && a[W-1]) ? -a : a;
  assign b_mag = (sgn && b[W-1]) ? -b : b;

`ifdef MDU_DIV_EN
  assign accept = (state == IDLE) && start;
`else
  assign accept = (state == IDLE) && start && !op[1];
`endif

  // acc_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first)
  always_comb begin
    madd  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    it_hi = madd[W:1];
    it_lo = {madd[0], acc_lo[W-1:1]};
`ifdef MDU_DIV_EN
    shifted = {acc_hi, acc_lo[W-1]};
    // partial remainder stays below the divisor, so the difference fits in W bits
    rem_sub = shifted[W-1:0] - opnd;
    if (is_div) begin
      if (shifted >= {1'b0, opnd}) begin
        it_hi = rem_sub;
        it_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        it_hi = shifted[W-1:0];
        it_lo = {acc_lo[W-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    prod  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fx_hi = prod[2*W-1:W];
    fx_lo = prod[W-1:0];
`ifdef MDU_DIV_EN
    // divide by zero naturally leaves |a| as remainder; only the quotient needs forcing
    q_fix = div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix = neg_r ? -acc_hi : acc_hi;
    if (is_div) begin
      fx_hi = r_fix;
      fx_lo = q_fix;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= CALC;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= b_mag;
            opnd   <= a_mag;
            neg_q  <= sgn & (a[W-1] ^ b[W-1]);
`ifdef MDU_DIV_EN
            is_div <= op[1];
            neg_r  <= sgn & a[W-1];
            div0   <= (b == '0);
            if (op[1]) begin
              acc_lo <= a_mag;
              opnd   <= b_mag;
            end
`endif
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        CALC: begin
          acc_hi <= it_hi;
          acc_lo <= it_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= fx_hi;
          lo    <= fx_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized + directed bench for mdu against a cycle-level transaction model.
module tb_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mdu #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int q;
    int rm;
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          q  = $signed(x) / $signed(y);
          rm = $signed(x) % $signed(y);
          r  = {rm, q};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Transaction model: m_left counts busy cycles still to go after an accepted start.
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_done;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (start && (DIV_EN || !op[1])) begin
        m_left <= 33;
        m_res  <= ref_calc(op, a, b);
      end else begin
        if (mthi) m_hi <= a;
        if (mtlo) m_lo <= a;
      end
    end else begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle{hi,lo,busy,done}", {hi, lo, busy, done}, {m_hi, m_lo, (m_left != 0), m_done});
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int bc);
    int n;
    bc = 0;
    n = 0;
    while (!done && n < 200) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    check("done_seen", 66'(done), 66'd1);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int bc;
  int dcnt;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {hi, lo, busy, done}, 66'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // model pins
    check("model_mult", 66'(ref_calc(2'b00, 32'hFFFF_FFFF, 32'd2)), 66'h0_FFFF_FFFF_FFFF_FFFE);
    check("model_multu", 66'(ref_calc(2'b01, 32'hFFFF_FFFF, 32'd2)), 66'h0_0000_0001_FFFF_FFFE);
    check("model_div", 66'(ref_calc(2'b10, 32'hFFFF_FFF9, 32'd2)), 66'h0_FFFF_FFFF_FFFF_FFFD);
    check("model_divu", 66'(ref_calc(2'b11, 32'd100, 32'd7)), 66'h0_0000_0002_0000_000E);

    issue(2'b00, 32'hFFFF_FFFF, 32'd2);
    wait_done(bc);
    check("mult_hilo", 66'({hi, lo}), 66'h0_FFFF_FFFF_FFFF_FFFE);
    check("mult_busy_cycles", 66'(bc), 66'd33);

    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_done(bc);
    check("multu_hilo", 66'({hi, lo}), 66'h0_0000_0001_FFFF_FFFE);

`ifdef MDU_DIV_EN
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    check("div_neg", 66'({hi, lo}), 66'h0_FFFF_FFFF_FFFF_FFFD);
    issue(2'b11, 32'd100, 32'd7);
    wait_done(bc);
    check("divu", 66'({hi, lo}), 66'h0_0000_0002_0000_000E);
    issue(2'b11, 32'h1234_5678, 32'd0);
    wait_done(bc);
    check("divu_by0", 66'({hi, lo}), 66'h0_1234_5678_FFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    check("div_ovf", 66'({hi, lo}), 66'h0_0000_0000_8000_0000);
    check("div_busy_cycles", 66'(bc), 66'd33);
`else
    issue(2'b10, 32'd100, 32'd7);
    check("div_disabled_busy", 66'(busy), 66'd0);
    repeat (40) @(negedge clk);
    check("div_disabled_hilo", 66'({hi, lo}), 66'h0_0000_0001_FFFF_FFFE);
`endif

    // moves and restart while busy are ignored
    issue(2'b00, 32'h0000_1234, 32'h0000_0010);
    repeat (3) @(negedge clk);
    mthi = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("busy_ignores", 66'({hi, lo}), 66'h0_0000_0000_0001_2340);
    @(negedge clk);
    mthi = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", 66'({hi, lo}), 66'h0_A5A5_A5A5_0001_2340);
    check("mthi_no_done", 66'(done), 66'd0);

    // asynchronous reset mid-operation
    issue(2'b00, 32'h1111_1111, 32'h2222_2222);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {hi, lo, busy, done}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("reset_no_done", 66'(dcnt), 66'd0);
    issue(2'b00, 32'd3, 32'd5);
    wait_done(bc);
    check("mult_3x5", 66'({hi, lo}), 66'h0_0000_0000_0000_000F);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 1300 == 650) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      a     = pick($urandom_range(0, 7));
      b     = pick($urandom_range(0, 7));
      mthi  = ($urandom_range(0, 7) == 0);
      mtlo  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the operand and HI/LO width; all values in this document are for W=32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin the operation selected by op.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port a, input, W bits: multiplicand or dividend.
REQ-007 The block SHALL have port b, input, W bits: multiplier or divisor.
REQ-008 The block SHALL have port mthi, input, 1 bit: write a into hi.
REQ-009 The block SHALL have port mtlo, input, 1 bit: write a into lo.
REQ-010 The block SHALL have port hi, output, W bits: HI register, fed to the downstream 32-bit 2:1 result select.
REQ-011 The block SHALL have port lo, output, W bits: LO register, fed to the same 2:1 result select.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo receive a result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, FIXUP; busy SHALL equal (state != IDLE), decoded from the state register.
REQ-015 In IDLE, start=1 at a rising edge SHALL be accepted: latch op, latch operand magnitudes (signed ops) or raw values (unsigned ops), record result signs, clear the 5-bit counter, enter CALC.
REQ-016 CALC SHALL perform one iteration per cycle (shift-add multiply, or restoring divide) for exactly 32 cycles, then enter FIXUP.
REQ-017 FIXUP SHALL apply sign correction and write hi/lo at its edge, return to IDLE and assert done for exactly the following cycle.
REQ-018 Latency: for acceptance at edge k, hi/lo SHALL update at edge k+33, busy SHALL be high for cycles k+1..k+33, and done SHALL be high for cycle k+34 only.
REQ-019 Multiply SHALL write the 64-bit product as {hi,lo}; MULT treats a and b as two's complement, MULTU as unsigned.
REQ-020 Divide SHALL write lo=quotient and hi=remainder; DIV truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 Divide by zero (b=0) SHALL write lo=0xFFFFFFFF and hi=a, for both DIV and DIVU.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL write lo=0x80000000 and hi=0.
REQ-023 start, mthi and mtlo SHALL be ignored while busy; a, b and op SHALL have no effect after the accepting edge.
REQ-024 In IDLE, mthi/mtlo SHALL write a into hi/lo at the next edge and SHALL NOT assert done.
REQ-025 If start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the moves SHALL be dropped.
REQ-026 hi/lo SHALL hold their values during CALC and FIXUP until the FIXUP edge.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0, without waiting for a clock edge.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse and no hi/lo write.
REQ-029 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-030 With macro MDU_DIV_EN defined, the divider SHALL be built and DIV/DIVU SHALL behave per REQ-020..REQ-022.
REQ-031 Without MDU_DIV_EN, no divide logic SHALL be built, start with op[1]=1 SHALL be ignored (no busy, no done, hi/lo unchanged), and multiply timing SHALL be unchanged.

Verification
REQ-032 MULT a=0xFFFFFFFF, b=0x00000002 -> at done: hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
REQ-033 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-035 DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 mthi with a=0xA5A5A5A5 while busy, then start pulsed mid-operation -> both ignored and the original result written; the same mthi in IDLE -> hi=0xA5A5A5A5 with no done pulse.
REQ-037 rst_n pulsed low at cycle 10 of a MULT -> hi=lo=0, busy=0 immediately, no done pulse; a new MULT 3*5 -> lo=15, hi=0.
